// File: rtl/id_stage_pkg.sv
// Shared decode constants, aluop/alusel codes and the instruction decoder
// used by id_stage.
package id_stage_pkg;

  localparam logic        RstEna    = 1'b1;
  localparam logic        ReadEna   = 1'b1;
  localparam logic        ReadDisa  = 1'b0;
  localparam logic        WriteEna  = 1'b1;
  localparam logic        WriteDisa = 1'b0;
  localparam logic [4:0]  NOPRegAddr = 5'd0;
  localparam logic [31:0] ZeroWord  = 32'h0;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [7:0] EXE_NOP_OP = 8'h00;
  localparam logic [7:0] EXE_AND_OP = 8'h24;
  localparam logic [7:0] EXE_OR_OP  = 8'h25;
  localparam logic [7:0] EXE_XOR_OP = 8'h26;
  localparam logic [7:0] EXE_NOR_OP = 8'h27;
  localparam logic [7:0] EXE_SLL_OP = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP = 8'h02;
  localparam logic [7:0] EXE_SRA_OP = 8'h03;

  localparam logic [2:0] EXE_RES_NOP   = 3'd0;
  localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
  localparam logic [2:0] EXE_RES_SHIFT = 3'd2;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        wreg;
    logic        err;
    logic        r1_en;
    logic        r2_en;
    logic        imm1_sel;  // reg1 operand is the shamt immediate
    logic        imm2_sel;  // reg2 operand is the I-type immediate
    logic [4:0]  waddr;
    logic [31:0] imm;
  } dec_t;

  function automatic logic [7:0] fn_aluop(input logic [5:0] fn);
    case (fn)
      FN_AND:                  fn_aluop = EXE_AND_OP;
      FN_OR:                   fn_aluop = EXE_OR_OP;
      FN_XOR:                  fn_aluop = EXE_XOR_OP;
      FN_NOR:                  fn_aluop = EXE_NOR_OP;
      FN_SLL, FN_SLLV:         fn_aluop = EXE_SLL_OP;
      FN_SRL, FN_SRLV:         fn_aluop = EXE_SRL_OP;
      FN_SRA, FN_SRAV:         fn_aluop = EXE_SRA_OP;
      default:                 fn_aluop = EXE_NOP_OP;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    // All-zero is the NOP bundle: NOP codes, no reads, no write, NOPRegAddr.
    d = '0;
    case (inst[31:26])
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        d.alusel   = EXE_RES_LOGIC;
        d.wreg     = WriteEna;
        d.waddr    = inst[20:16];
        d.r1_en    = ReadEna;
        d.imm2_sel = 1'b1;
        d.imm      = {16'h0, inst[15:0]};
        case (inst[31:26])
          OP_ANDI: d.aluop = EXE_AND_OP;
          OP_XORI: d.aluop = EXE_XOR_OP;
          OP_LUI: begin
            d.aluop = EXE_OR_OP;
            d.imm   = {inst[15:0], 16'h0};
          end
          default: d.aluop = EXE_OR_OP;
        endcase
      end
      OP_SPECIAL: begin
        if (inst != ZeroWord) begin
          case (inst[5:0])
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              d.alusel = EXE_RES_LOGIC;
              d.r1_en  = ReadEna;
              d.r2_en  = ReadEna;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              d.alusel   = EXE_RES_SHIFT;
              d.r2_en    = ReadEna;
              d.imm1_sel = 1'b1;
              d.imm      = {27'h0, inst[10:6]};
            end
            FN_SLLV, FN_SRLV, FN_SRAV: begin
              d.alusel = EXE_RES_SHIFT;
              d.r1_en  = ReadEna;
              d.r2_en  = ReadEna;
            end
            default: d.err = 1'b1;
          endcase
          if (!d.err) begin
            d.aluop = fn_aluop(inst[5:0]);
            d.wreg  = WriteEna;
            d.waddr = inst[15:11];
          end
        end
      end
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-source operand select (zero / EX / MEM / regfile) and RAW hazard detect.
// ID_FORWARD_EN enables the EX/MEM bypass; without it any pending write stalls.
module id_fwd_mux
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              rd_en_i,
  input  logic [REG_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              hazard_o
);

  logic live, ex_hit, mem_hit;

  // $0 and disabled reads never hit, so they never stall or forward.
  assign live    = (rd_en_i == ReadEna) && (addr_i != '0);
  assign ex_hit  = live && ex_wreg_i  && (ex_waddr_i  == addr_i);
  assign mem_hit = live && mem_wreg_i && (mem_waddr_i == addr_i);

`ifdef ID_FORWARD_EN
  always_comb begin
    data_o = '0;
    if (!live)        data_o = '0;
    else if (ex_hit)  data_o = ex_wdata_i;
    else if (mem_hit) data_o = mem_wdata_i;
    else              data_o = rf_data_i;
  end
  // A load's data is not available in EX yet; only that case must wait.
  assign hazard_o = ex_hit && ex_is_load_i;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
  assign data_o     = live ? rf_data_i : '0;
  assign hazard_o   = ex_hit || mem_hit;
`endif

endmodule

// File: rtl/id_stage.sv
// Decode stage with ID/EX register and valid/ready handshake.
// ID_FORWARD_EN selects EX/MEM forwarding; undefined means stall-only.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  input  logic              flush_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic              wreg_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic              inst_err_o
);

  localparam int NSRC = 2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [7:0]        aluop;
    logic [2:0]        alusel;
    logic              wreg;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              err;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = '{
    pc: '0, aluop: EXE_NOP_OP, alusel: EXE_RES_NOP, wreg: WriteDisa,
    waddr: REG_AW'(NOPRegAddr), reg1: '0, reg2: '0, err: 1'b0};

  dec_t                        dec;
  logic [NSRC-1:0]             src_en, src_haz;
  logic [NSRC-1:0][REG_AW-1:0] src_addr;
  logic [NSRC-1:0][DATA_W-1:0] src_rf, src_data;
  logic                        hazard, accept;
  logic                        out_valid_d, out_valid_q;
  bundle_t                     bundle_d, bundle_q;

  assign dec         = decode(inst_i);
  assign reg1_read_o = dec.r1_en;
  assign reg2_read_o = dec.r2_en;
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  assign src_en   = {dec.r2_en, dec.r1_en};
  assign src_addr = {reg2_addr_o, reg1_addr_o};
  assign src_rf   = {reg2_data_i, reg1_data_i};

  generate
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
        .rd_en_i     (src_en[s]),
        .addr_i      (src_addr[s]),
        .rf_data_i   (src_rf[s]),
        .ex_wreg_i   (ex_wreg_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i  (mem_wreg_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .data_o      (src_data[s]),
        .hazard_o    (src_haz[s])
      );
    end
  endgenerate

  // Hazard is a function of the offered word only, so ready never waits on valid.
  assign hazard     = |src_haz;
  assign in_ready_o = (rst != RstEna) && !flush_i && !hazard &&
                      (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d     = 1'b1;
      bundle_d.pc     = pc_i;
      bundle_d.aluop  = dec.aluop;
      bundle_d.alusel = dec.alusel;
      bundle_d.wreg   = dec.wreg;
      bundle_d.waddr  = REG_AW'(dec.waddr);
      bundle_d.reg1   = dec.imm1_sel ? DATA_W'(dec.imm) : src_data[0];
      bundle_d.reg2   = dec.imm2_sel ? DATA_W'(dec.imm) : src_data[1];
      bundle_d.err    = dec.err;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEna) begin
      out_valid_q <= 1'b0;
      bundle_q    <= BUNDLE_RST;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign pc_o        = bundle_q.pc;
  assign aluop_o     = bundle_q.aluop;
  assign alusel_o    = bundle_q.alusel;
  assign wreg_o      = bundle_q.wreg;
  assign waddr_o     = bundle_q.waddr;
  assign reg1_o      = bundle_q.reg1;
  assign reg2_o      = bundle_q.reg2;
  assign inst_err_o  = bundle_q.err;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode table, handshake/hazard sequences,
// then randomized traffic against a mnemonic-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o, flush_i;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_waddr_i, mem_waddr_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        out_valid_o, out_ready_i, wreg_o, inst_err_o;
  logic [31:0] pc_o, reg1_o, reg2_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [4:0]  waddr_o;

  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  id_stage #(.DATA_W(32), .REG_AW(5), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i), .mem_wreg_i(mem_wreg_i),
    .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .wreg_o(wreg_o), .waddr_o(waddr_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .inst_err_o(inst_err_o)
  );

  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] reg1, reg2;
    logic        err;
    logic        rd1, rd2;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] reg1, reg2;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] aluop, input logic [2:0] alusel,
                         input logic wreg, input logic [4:0] waddr,
                         input logic [31:0] r1, input logic [31:0] r2, input logic err);
    chk({nm, " aluop"},  32'(aluop_o),    32'(aluop));
    chk({nm, " alusel"}, 32'(alusel_o),   32'(alusel));
    chk({nm, " wreg"},   32'(wreg_o),     32'(wreg));
    chk({nm, " waddr"},  32'(waddr_o),    32'(waddr));
    chk({nm, " reg1"},   reg1_o,          r1);
    chk({nm, " reg2"},   reg2_o,          r2);
    chk({nm, " err"},    32'(inst_err_o), 32'(err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  // ---------------- reference model (mnemonic level) ----------------
  function automatic string mnem(input logic [31:0] w);
    if (w == 32'h0) return "nop";
    case (w[31:26])
      6'h0d: return "ori";
      6'h0c: return "andi";
      6'h0e: return "xori";
      6'h0f: return "lui";
      6'h00:
        case (w[5:0])
          6'h24: return "and";
          6'h25: return "or";
          6'h26: return "xor";
          6'h27: return "nor";
          6'h00: return "sll";
          6'h02: return "srl";
          6'h03: return "sra";
          6'h04: return "sllv";
          6'h06: return "srlv";
          6'h07: return "srav";
          default: return "bad";
        endcase
      default: return "bad";
    endcase
  endfunction

  function automatic logic [31:0] src(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef ID_FORWARD_EN
    if (ex_wreg_i && ex_waddr_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_waddr_i == a) return mem_wdata_i;
`endif
    return rf[a];
  endfunction

  function automatic exp_t ref_model(input logic [31:0] w);
    exp_t e;
    string m;
    m = mnem(w);
    e = '{default: '0};
    if (m == "nop" || m == "bad") begin
      e.err = (m == "bad");
      return e;
    end
    e.wreg = 1'b1;
    if (m == "and" || m == "andi")                    e.aluop = 8'h24;
    else if (m == "or" || m == "ori" || m == "lui")   e.aluop = 8'h25;
    else if (m == "xor" || m == "xori")               e.aluop = 8'h26;
    else if (m == "nor")                              e.aluop = 8'h27;
    else if (m == "sll" || m == "sllv")               e.aluop = 8'h7C;
    else if (m == "srl" || m == "srlv")               e.aluop = 8'h02;
    else                                              e.aluop = 8'h03;
    e.alusel = (e.aluop inside {8'h7C, 8'h02, 8'h03}) ? 3'd2 : 3'd1;
    if (m == "ori" || m == "andi" || m == "xori" || m == "lui") begin
      e.waddr = w[20:16];
      e.rd1   = 1'b1;
      e.reg1  = src(w[25:21]);
      e.reg2  = (m == "lui") ? {w[15:0], 16'h0} : {16'h0, w[15:0]};
    end else if (m == "sll" || m == "srl" || m == "sra") begin
      e.waddr = w[15:11];
      e.rd2   = 1'b1;
      e.reg1  = {27'h0, w[10:6]};
      e.reg2  = src(w[20:16]);
    end else begin
      e.waddr = w[15:11];
      e.rd1   = 1'b1;
      e.rd2   = 1'b1;
      e.reg1  = src(w[25:21]);
      e.reg2  = src(w[20:16]);
    end
    return e;
  endfunction

  function automatic logic pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef ID_FORWARD_EN
    return ex_wreg_i && ex_is_load_i && ex_waddr_i == a;
`else
    return (ex_wreg_i && ex_waddr_i == a) || (mem_wreg_i && mem_waddr_i == a);
`endif
  endfunction

  function automatic logic ref_hazard(input logic [31:0] w);
    exp_t e;
    e = ref_model(w);
    return (e.rd1 && pending(w[25:21])) || (e.rd2 && pending(w[20:16]));
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [5:0]  iops [4]  = '{6'h0d, 6'h0c, 6'h0e, 6'h0f};
    logic [5:0]  fns  [10] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    int k;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); sa = 5'($urandom);
    imm = 16'($urandom);
    k = int'($urandom_range(0, 17));
    if (k < 4)        return enc_i(iops[k], rs, rt, imm);
    else if (k < 14)  return enc_r(rs, rt, rd, sa, fns[k-4]);
    else if (k == 14) return 32'h0;
    else if (k == 15) return enc_i(6'h3F, rs, rt, imm);
    else if (k == 16) return enc_r(rs, rt, rd, sa, 6'h3F);
    return $urandom;
  endfunction

  vec_t  vecs [17];
  exp_t  m_b;
  logic  m_valid, exp_rdy;
  logic [31:0] m_pc;

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; pc_i = '0; inst_i = '0;
    ex_wreg_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0; out_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'h12340000; rf[2] = 32'hF0F0000F; rf[3] = 32'h80000010;
    rf[4] = 32'h00C0FFEE; rf[5] = 32'h13579BDF; rf[6] = 32'h2468ACE0;
    rf[7] = 32'h7FFFFFFF;

    vecs[0]  = '{enc_i(6'h0d, 5'd1, 5'd2, 16'h00FF), 8'h25, 3'd1, 1'b1, 5'd2, rf[1], 32'h000000FF, 1'b0};
    vecs[1]  = '{enc_i(6'h0c, 5'd2, 5'd3, 16'h8001), 8'h24, 3'd1, 1'b1, 5'd3, rf[2], 32'h00008001, 1'b0};
    vecs[2]  = '{enc_i(6'h0e, 5'd3, 5'd4, 16'hFFFF), 8'h26, 3'd1, 1'b1, 5'd4, rf[3], 32'h0000FFFF, 1'b0};
    vecs[3]  = '{enc_i(6'h0f, 5'd0, 5'd5, 16'hABCD), 8'h25, 3'd1, 1'b1, 5'd5, 32'h0, 32'hABCD0000, 1'b0};
    vecs[4]  = '{enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h24), 8'h24, 3'd1, 1'b1, 5'd6, rf[1], rf[2], 1'b0};
    vecs[5]  = '{enc_r(5'd2, 5'd3, 5'd7, 5'd0, 6'h25), 8'h25, 3'd1, 1'b1, 5'd7, rf[2], rf[3], 1'b0};
    vecs[6]  = '{enc_r(5'd3, 5'd1, 5'd1, 5'd0, 6'h26), 8'h26, 3'd1, 1'b1, 5'd1, rf[3], rf[1], 1'b0};
    vecs[7]  = '{enc_r(5'd1, 5'd1, 5'd2, 5'd0, 6'h27), 8'h27, 3'd1, 1'b1, 5'd2, rf[1], rf[1], 1'b0};
    vecs[8]  = '{enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h00), 8'h7C, 3'd2, 1'b1, 5'd3, 32'd4, rf[2], 1'b0};
    vecs[9]  = '{enc_r(5'd0, 5'd3, 5'd4, 5'd31, 6'h02), 8'h02, 3'd2, 1'b1, 5'd4, 32'd31, rf[3], 1'b0};
    vecs[10] = '{enc_r(5'd0, 5'd1, 5'd5, 5'd1, 6'h03), 8'h03, 3'd2, 1'b1, 5'd5, 32'd1, rf[1], 1'b0};
    vecs[11] = '{enc_r(5'd4, 5'd2, 5'd6, 5'd0, 6'h04), 8'h7C, 3'd2, 1'b1, 5'd6, rf[4], rf[2], 1'b0};
    vecs[12] = '{enc_r(5'd5, 5'd3, 5'd7, 5'd0, 6'h06), 8'h02, 3'd2, 1'b1, 5'd7, rf[5], rf[3], 1'b0};
    vecs[13] = '{enc_r(5'd6, 5'd1, 5'd1, 5'd0, 6'h07), 8'h03, 3'd2, 1'b1, 5'd1, rf[6], rf[1], 1'b0};
    vecs[14] = '{32'h0, 8'h00, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0};
    vecs[15] = '{enc_i(6'h3F, 5'd1, 5'd2, 16'h1234), 8'h00, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1};
    vecs[16] = '{enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 8'h00, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1};

    // Reset state, with an instruction offered that must not be taken.
    in_valid_i = 1'b1; inst_i = vecs[0].inst; pc_i = 32'hDEAD0000;
    tick(); tick();
    chk("rst in_ready", 32'(in_ready_o), 0);
    chk("rst out_valid", 32'(out_valid_o), 0);
    chk("rst pc", pc_o, 0);
    chk_out("rst", 8'h00, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0; in_valid_i = 1'b0;
    tick();

    // Decode table, back-to-back at full throughput.
    for (int i = 0; i < 17; i++) begin
      in_valid_i = 1'b1; inst_i = vecs[i].inst; pc_i = 32'h100 + 32'(4 * i);
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready_o), 1);
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid_o), 1);
      chk($sformatf("vec%0d pc", i), pc_o, 32'h100 + 32'(4 * i));
      chk_out($sformatf("vec%0d", i), vecs[i].aluop, vecs[i].alusel, vecs[i].wreg,
              vecs[i].waddr, vecs[i].reg1, vecs[i].reg2, vecs[i].err);
    end
    in_valid_i = 1'b0;
    tick();
    chk("drain out_valid", 32'(out_valid_o), 0);

    // EX and MEM both target $1: EX wins.
    in_valid_i = 1'b1; inst_i = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
    ex_wreg_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'hA5A5A5A5; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h1;
    #1;
`ifdef ID_FORWARD_EN
    chk("fwd in_ready", 32'(in_ready_o), 1);
    tick();
    chk("fwd reg1", reg1_o, 32'hA5A5A5A5);
    chk("fwd reg2", reg2_o, rf[2]);
`else
    chk("nofwd stall in_ready", 32'(in_ready_o), 0);
    tick();
    chk("nofwd bubble", 32'(out_valid_o), 0);
    ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;
    #1;
    chk("nofwd in_ready", 32'(in_ready_o), 1);
    tick();
    chk("nofwd reg1", reg1_o, rf[1]);
`endif

    // Load-use on $4, then MEM supplies it.
    inst_i = enc_i(6'h0e, 5'd4, 5'd5, 16'h0001);
    ex_wreg_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd4; ex_wdata_i = 32'hBAD0BAD0;
    mem_wreg_i = 1'b0;
    #1;
    chk("load-use in_ready", 32'(in_ready_o), 0);
    tick();
    chk("load-use bubble", 32'(out_valid_o), 0);
    ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b1; mem_waddr_i = 5'd4; mem_wdata_i = 32'h10;
    #1;
`ifdef ID_FORWARD_EN
    chk("load-use resume", 32'(in_ready_o), 1);
    tick();
    chk("load-use valid", 32'(out_valid_o), 1);
    chk("load-use reg1", reg1_o, 32'h10);
`else
    chk("mem stall in_ready", 32'(in_ready_o), 0);
    tick();
    mem_wreg_i = 1'b0;
    #1;
    chk("load-use resume", 32'(in_ready_o), 1);
    tick();
    chk("load-use valid", 32'(out_valid_o), 1);
    chk("load-use reg1", reg1_o, rf[4]);
`endif
    chk("load-use reg2", reg2_o, 32'h1);
    mem_wreg_i = 1'b0; in_valid_i = 1'b0;
    tick();

    // Backpressure: A held while B waits, B taken as ready rises.
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    inst_i = enc_i(6'h0d, 5'd1, 5'd2, 16'h1111); pc_i = 32'h200;
    #1;
    chk("bp A in_ready", 32'(in_ready_o), 1);
    tick();
    inst_i = enc_i(6'h0c, 5'd3, 5'd6, 16'h2222); pc_i = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp hold%0d in_ready", c), 32'(in_ready_o), 0);
      tick();
      chk($sformatf("bp hold%0d valid", c), 32'(out_valid_o), 1);
      chk($sformatf("bp hold%0d pc", c), pc_o, 32'h200);
      chk($sformatf("bp hold%0d reg2", c), reg2_o, 32'h1111);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp B in_ready", 32'(in_ready_o), 1);
    tick();
    chk("bp B valid", 32'(out_valid_o), 1);
    chk("bp B pc", pc_o, 32'h204);
    chk("bp B waddr", 32'(waddr_o), 6);
    chk("bp B reg2", reg2_o, 32'h2222);

    // Flush with a held bundle and an incoming instruction.
    out_ready_i = 1'b0; flush_i = 1'b1;
    inst_i = enc_i(6'h0e, 5'd1, 5'd7, 16'h3333); pc_i = 32'h208;
    #1;
    chk("flush in_ready", 32'(in_ready_o), 0);
    tick();
    chk("flush valid", 32'(out_valid_o), 0);
    flush_i = 1'b0; in_valid_i = 1'b0;
    tick();
    chk("flush stays empty", 32'(out_valid_o), 0);
    chk("flush not loaded pc", pc_o, 32'h204);

    // $0 sources never forward nor stall.
    out_ready_i = 1'b1; in_valid_i = 1'b1; inst_i = enc_r(5'd0, 5'd0, 5'd6, 5'd0, 6'h25);
    ex_wreg_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFFFFFFFF;
    mem_wreg_i = 1'b1; mem_waddr_i = 5'd0; mem_wdata_i = 32'hDEAD;
    #1;
    chk("r0 in_ready", 32'(in_ready_o), 1);
    tick();
    chk("r0 reg1", reg1_o, 32'h0);
    chk("r0 reg2", reg2_o, 32'h0);

    // Reset in the middle of a stall with a held bundle.
    out_ready_i = 1'b0; mem_wreg_i = 1'b0;
    inst_i = enc_i(6'h0e, 5'd4, 5'd5, 16'h0001); ex_waddr_i = 5'd4;
    tick();
    rst = 1'b1;
    tick();
    chk("rst-stall valid", 32'(out_valid_o), 0);
    chk("rst-stall aluop", 32'(aluop_o), 0);
    chk("rst-stall in_ready", 32'(in_ready_o), 0);
    rst = 1'b0; in_valid_i = 1'b0; ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
    tick();

    // Randomized traffic against the reference model.
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    m_valid = 1'b0; m_pc = '0; m_b = '{default: '0};
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      in_valid_i   = ($urandom_range(0, 3) != 0);
      inst_i       = rnd_inst();
      pc_i         = $urandom;
      flush_i      = ($urandom_range(0, 19) == 0);
      out_ready_i  = ($urandom_range(0, 3) != 0);
      ex_wreg_i    = ($urandom_range(0, 1) == 0);
      ex_waddr_i   = 5'($urandom_range(0, 7));
      ex_wdata_i   = $urandom;
      ex_is_load_i = ($urandom_range(0, 2) == 0);
      mem_wreg_i   = ($urandom_range(0, 1) == 0);
      mem_waddr_i  = 5'($urandom_range(0, 7));
      mem_wdata_i  = $urandom;
      #1;
      exp_rdy = !rst && !flush_i && !ref_hazard(inst_i) && (!m_valid || out_ready_i);
      chk("rand in_ready", 32'(in_ready_o), 32'(exp_rdy));
      if (rst) m_valid = 1'b0;
      else if (flush_i) m_valid = 1'b0;
      else if (in_valid_i && exp_rdy) begin
        m_valid = 1'b1; m_b = ref_model(inst_i); m_pc = pc_i;
      end else if (out_ready_i) m_valid = 1'b0;
      tick();
      chk("rand out_valid", 32'(out_valid_o), 32'(m_valid));
      if (m_valid) begin
        chk("rand pc", pc_o, m_pc);
        chk_out("rand", m_b.aluop, m_b.alusel, m_b.wreg, m_b.waddr, m_b.reg1, m_b.reg2, m_b.err);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
